// File: rtl/cache_set_requester.sv
// Initiator for the CacheSetInterface: issues a request or flush, waits the
// responder latency, captures and checks the response, and hands it downstream.
module cache_set_requester #(
  parameter int DATA_W       = 8,
  parameter int RESP_LATENCY = 1,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  input  logic              cmd_flush,
  output logic [DATA_W-1:0] request,
  output logic              set_clear,
  input  logic [DATA_W-1:0] response,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic              res_ok,
  output logic [CNT_W-1:0]  mismatch_count
);

  localparam int LAT_W =
    (RESP_LATENCY < 1) ? 1 : $clog2(RESP_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] req_q;
  logic [DATA_W-1:0] exp_q;
  logic              clr_q;
  logic              vld_q;
  logic [DATA_W-1:0] data_q;
  logic              ok_q;
  logic [CNT_W-1:0]  mis_q;

  logic              hit_d;
  logic [CNT_W-1:0]  mis_d;

  always_comb begin
    hit_d = (response == exp_q);
    mis_d = mis_q;
    if (!hit_d && (mis_q != {CNT_W{1'b1}})) begin
      mis_d = mis_q + CNT_W'(1);
    end
  end

  // Request and clear stay frozen from accept through the capture edge.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      exp_q   <= '0;
      clr_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      ok_q    <= 1'b0;
      mis_q   <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            if (cmd_flush) begin
              req_q <= '0;
              exp_q <= '0;
              clr_q <= 1'b1;
            end else begin
              req_q <= cmd_data;
              exp_q <= ~cmd_data;
              clr_q <= 1'b0;
            end
            cnt_q   <= LAT_W'(RESP_LATENCY);
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            data_q  <= response;
            ok_q    <= hit_d;
            vld_q   <= 1'b1;
            clr_q   <= 1'b0;
            mis_q   <= mis_d;
            state_q <= S_DONE;
          end else begin
            cnt_q <= cnt_q - LAT_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            vld_q   <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready      = (state_q == S_IDLE);
  assign request        = req_q;
  assign set_clear      = clr_q;
  assign res_valid      = vld_q;
  assign res_data       = data_q;
  assign res_ok         = ok_q;
  assign mismatch_count = mis_q;

endmodule

// File: tb/tb_cache_set_requester.sv
// Bench: directed and random commands against behavioural CacheSet
// responders, for the default build and a latency-3 / 2-bit-counter build.
module tb_cache_set_requester;

  logic       clk;
  logic       clear_n;

  logic       cmd_valid, cmd_ready, cmd_flush;
  logic [7:0] cmd_data, request, response, res_data;
  logic       set_clear, res_valid, res_ready, res_ok;
  logic [15:0] mismatch_count;

  logic       cmd_valid2, cmd_ready2, cmd_flush2;
  logic [7:0] cmd_data2, request2, response2, res_data2;
  logic       set_clear2, res_valid2, res_ready2, res_ok2;
  logic [1:0] mismatch_count2;

  int errs   = 0;
  int checks = 0;

  bit   bad_mode  = 0;
  bit   bad_mode2 = 0;
  int   mis_model  = 0;
  int   mis_model2 = 0;

  cache_set_requester dut (
    .clock(clk), .clear_n(clear_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_data(cmd_data), .cmd_flush(cmd_flush),
    .request(request), .set_clear(set_clear),
    .response(response),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_ok(res_ok),
    .mismatch_count(mismatch_count)
  );

  cache_set_requester #(.DATA_W(8), .RESP_LATENCY(3), .CNT_W(2)) dut2 (
    .clock(clk), .clear_n(clear_n),
    .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_data(cmd_data2), .cmd_flush(cmd_flush2),
    .request(request2), .set_clear(set_clear2),
    .response(response2),
    .res_valid(res_valid2), .res_ready(res_ready2),
    .res_data(res_data2), .res_ok(res_ok2),
    .mismatch_count(mismatch_count2)
  );

  // CacheSet responder: registers ~request, or 0 under clear.
  logic [7:0] set_q;
  always_ff @(posedge clk)
    set_q <= set_clear ? 8'h00 : ~request;
  assign response = bad_mode ? 8'h00 : set_q;

  // Three-stage delayed responder for the latency-3 build.
  logic [7:0] d1, d2, d3;
  always_ff @(posedge clk) begin
    d1 <= set_clear2 ? 8'h00 : ~request2;
    d2 <= d1;
    d3 <= d2;
  end
  assign response2 = bad_mode2 ? 8'h00 : d3;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  // One full transaction on the default build with a hold of `hold` cycles.
  task automatic do_cmd(input logic [7:0] d, input bit fl,
                        input bit bad, input int hold);
    logic [7:0] expv, got;
    bit         ok;
    int         n;
    expv = fl ? 8'h00 : ~d;
    got  = bad ? 8'h00 : expv;
    ok   = (got == expv);
    cmd_data = d; cmd_flush = fl; cmd_valid = 1;
    bad_mode = bad; res_ready = (hold == 0);
    n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    tick();
    cmd_valid = 0;
    chk("request_e0", request, fl ? 8'h00 : d);
    chk("set_clear_e0", set_clear, fl);
    n = 0;
    while (!res_valid && n < 20) begin
      tick(); n++;
      if (!res_valid) chk("set_clear_wait", set_clear, fl);
    end
    chk("latency", n, 2);
    mis_model = ok ? mis_model : sat_inc(mis_model, 65535);
    chk("res_data", res_data, got);
    chk("res_ok", res_ok, ok);
    chk("mismatch_count", mismatch_count, mis_model);
    chk("set_clear_cap", set_clear, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, got);
      chk("hold_ready", cmd_ready, 0);
    end
    res_ready = 1;
    tick();
    chk("res_valid_drop", res_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("request_kept", request, fl ? 8'h00 : d);
    bad_mode = 0;
  endtask

  task automatic do_cmd2(input logic [7:0] d, input bit bad);
    logic [7:0] got;
    bit         ok;
    int         n;
    got = bad ? 8'h00 : ~d;
    ok  = (got == ~d);
    cmd_data2 = d; cmd_flush2 = 0; cmd_valid2 = 1;
    bad_mode2 = bad; res_ready2 = 1;
    n = 0;
    while (!cmd_ready2 && n < 50) begin tick(); n++; end
    tick();
    cmd_valid2 = 0;
    n = 0;
    while (!res_valid2 && n < 20) begin tick(); n++; end
    chk("l3_latency", n, 4);
    mis_model2 = ok ? mis_model2 : sat_inc(mis_model2, 3);
    chk("l3_res_data", res_data2, got);
    chk("l3_res_ok", res_ok2, ok);
    chk("l3_mismatch", mismatch_count2, mis_model2);
    tick();
    chk("l3_done", res_valid2, 0);
    bad_mode2 = 0;
  endtask

  initial begin
    clear_n = 0;
    cmd_valid = 0; cmd_data = 0; cmd_flush = 0; res_ready = 0;
    cmd_valid2 = 0; cmd_data2 = 0; cmd_flush2 = 0; res_ready2 = 0;
    tick(); tick();
    chk("rst_request", request, 0);
    chk("rst_set_clear", set_clear, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_mismatch", mismatch_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    clear_n = 1;
    tick();

    do_cmd(8'hA5, 0, 0, 0);
    do_cmd(8'h3C, 0, 0, 0);
    do_cmd(8'h00, 1, 0, 0);
    do_cmd(8'hFF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_cmd(8'h0F, 0, 1, 0);
    chk("mismatch_four", mismatch_count, 4);

    // Hold res_ready low in DONE while the next command waits upstream.
    cmd_data = 8'h22; cmd_flush = 0; cmd_valid = 1; res_ready = 0;
    tick();
    cmd_data = 8'h11;
    tick(); tick();
    chk("hold_first_valid", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold5_valid", res_valid, 1);
      chk("hold5_data", res_data, 8'hDD);
      chk("hold5_ok", res_ok, 1);
      chk("hold5_cmd_ready", cmd_ready, 0);
      chk("hold5_request", request, 8'h22);
    end
    res_ready = 1;
    tick();
    chk("pend_ready", cmd_ready, 1);
    chk("pend_not_taken", request, 8'h22);
    tick();
    cmd_valid = 0;
    chk("pend_accepted", request, 8'h11);
    tick(); tick();
    chk("pend_data", res_data, 8'hEE);
    tick();

    // Asynchronous reset in the middle of WAIT.
    cmd_data = 8'h5C; cmd_flush = 1; cmd_valid = 1;
    tick();
    cmd_valid = 0;
    #2 clear_n = 0;
    #1;
    mis_model = 0;
    chk("mid_rst_request", request, 0);
    chk("mid_rst_clear", set_clear, 0);
    chk("mid_rst_mis", mismatch_count, 0);
    chk("mid_rst_ready", cmd_ready, 1);
    #3 clear_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_rst_no_res", res_valid, 0);
    end
    do_cmd(8'h96, 0, 0, 0);

    for (int i = 0; i < 20; i++) begin
      do_cmd(8'($urandom), ($urandom % 4) == 0,
             ($urandom % 3) == 0, $urandom_range(0, 2));
    end

    do_cmd2(8'hC3, 0);
    for (int i = 0; i < 5; i++) do_cmd2(8'($urandom_range(0, 254)), 1);
    chk("l3_saturated", mismatch_count2, 3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
